// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory read bus between the fetch unit and memory
interface instr_fetch_unit_if #(parameter int instwidth = 32);
  logic                 imem_req;
  logic [instwidth-1:0] imem_addr;
  logic                 imem_ready;
  logic [instwidth-1:0] imem_rdata;
  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetcher with redirect and misaligned-target trap
module instr_fetch_unit #(
  parameter int                   instwidth = 32,
  parameter logic [instwidth-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_fetch_unit_if.master   imem,
  output logic [instwidth-1:0] inst,
  output logic                 inst_valid,
  input  logic                 inst_ack,
  input  logic                 redirect,
  input  logic [instwidth-1:0] redirect_pc,
  output logic [instwidth-1:0] pc,
  output logic [instwidth-1:0] pc_plus4,
  output logic                 fetch_err,
  output logic [31:0]          retired
);
  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD, S_TRAP} state_t;
  state_t state, state_nx;
  logic ack_ok, misaligned, load;
  assign ack_ok     = state == S_HOLD && inst_valid && inst_ack;
  assign misaligned = redirect && redirect_pc[1:0] != 2'b00;
  assign load       = state == S_FETCH && imem.imem_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_BOOT;
    else state <= state_nx;
  always_comb
    state_nx = state == S_BOOT ? S_FETCH :
               load            ? S_HOLD  :
               ack_ok          ? (misaligned ? S_TRAP : S_FETCH) : state;
  always_comb begin
    imem.imem_req  = state == S_FETCH;
    imem.imem_addr = pc;
    pc_plus4       = pc + instwidth'(4);
  end
  // Misaligned targets leave pc at the faulting instruction for post-mortem inspection.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc         <= RESET_PC;
      inst       <= instwidth'(32'h0000_0013);
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
      retired    <= '0;
    end else if (load) begin
      inst       <= imem.imem_rdata;
      inst_valid <= 1'b1;
    end else if (ack_ok) begin
      inst_valid <= 1'b0;
      retired    <= retired + 32'd1;
      if (misaligned) fetch_err <= 1'b1;
      else pc <= redirect ? redirect_pc : pc_plus4;
    end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter instwidth, default 32: instruction and PC width in bits.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-006 SHALL have port imem_addr  output  instwidth  read address, equal to pc.
REQ-007 SHALL have port imem_ready  input  1  read data valid this cycle.
REQ-008 SHALL have port imem_rdata  input  instwidth  instruction word.
REQ-009 SHALL have port inst  output  instwidth  registered instruction, fed to the control-address decoder.
REQ-010 SHALL have port inst_valid  output  1  inst holds a fetched, unconsumed instruction.
REQ-011 SHALL have port inst_ack  input  1  downstream has executed inst this cycle.
REQ-012 SHALL have port redirect  input  1  taken branch/jump, sampled only with inst_ack.
REQ-013 SHALL have port redirect_pc  input  instwidth  next PC when redirect=1.
REQ-014 SHALL have port pc  output  instwidth  address of inst.
REQ-015 SHALL have port pc_plus4  output  instwidth  pc+4, combinational.
REQ-016 SHALL have port fetch_err  output  1  sticky misaligned-target error.
REQ-017 SHALL have port retired  output  32  count of acknowledged instructions.

Function
REQ-018 SHALL implement FSM states S_BOOT, S_FETCH, S_HOLD, S_TRAP.
REQ-019 S_BOOT SHALL last exactly one cycle after reset release, with imem_req=0, then go to S_FETCH.
REQ-020 In S_FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; imem_req SHALL stay 1 every cycle until imem_ready=1.
REQ-021 In S_FETCH with imem_ready=1, inst SHALL load imem_rdata, inst_valid SHALL rise the next cycle, and the FSM SHALL go to S_HOLD; fetch latency is 1 cycle after imem_ready.
REQ-022 In S_HOLD, imem_req SHALL be 0, and inst and pc SHALL stay stable until inst_ack=1.
REQ-023 inst_ack SHALL be ignored when inst_valid=0.
REQ-024 In S_HOLD with inst_ack=1 and redirect=0, on the next edge: pc <= pc+4, inst_valid <= 0, retired <= retired+1, go to S_FETCH.
REQ-025 In S_HOLD with inst_ack=1 and redirect=1, with redirect_pc[1:0]==0: pc <= redirect_pc, inst_valid <= 0, retired increments, go to S_FETCH.
REQ-026 In S_HOLD with inst_ack=1, redirect=1 and redirect_pc[1:0]!=0: pc unchanged, fetch_err <= 1, inst_valid <= 0, retired increments, go to S_TRAP.
REQ-027 S_TRAP SHALL be absorbing until reset, with imem_req=0 and inst_valid=0.
REQ-028 pc+4 and redirect arithmetic SHALL be modulo 2^instwidth; 32'hFFFF_FFFC+4 wraps to 0 without error.
REQ-029 retired SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-030 imem_ready SHALL be ignored outside S_FETCH.

Reset
REQ-031 On rst=1, regardless of clock or state, the block SHALL set: pc=RESET_PC, inst=32'h0000_0013 (NOP), inst_valid=0, imem_req=0, fetch_err=0, retired=0, state S_BOOT.
REQ-032 Reset asserted mid-fetch SHALL discard the outstanding request; a late imem_ready after reset SHALL not load inst.

Verification
REQ-033 Release rst; imem_ready=1 always; imem_rdata=32'h00500093 -> first imem_req in cycle 2 at addr 0; inst=32'h00500093 and inst_valid=1 one cycle later.
REQ-034 Hold imem_ready=0 for 5 cycles in S_FETCH -> imem_req stays 1 and imem_addr stays constant; inst_valid=0 throughout.
REQ-035 inst_ack with redirect=1, redirect_pc=32'h0000_0100 -> next imem_addr=32'h100, pc=32'h100, retired incremented by 1.
REQ-036 inst_ack with redirect=1, redirect_pc=32'h0000_0102 -> fetch_err=1, imem_req=0 forever, pc unchanged until rst.
REQ-037 pc=32'hFFFF_FFFC, inst_ack, redirect=0 -> pc=0, fetch_err=0.
REQ-038 Assert rst while imem_req=1, then apply imem_ready=1 -> inst=32'h00000013, inst_valid=0, pc=RESET_PC.
